// File: rtl/tx_sample_feeder_if.sv
// Stream bundle between the transmitter control core and tx_sample_feeder:
// frequency, AM and control words, each a 32-bit stb/ack channel.
interface tx_sample_feeder_if;
    logic [31:0] input_tx_freq;
    logic        input_tx_freq_stb;
    logic        input_tx_freq_ack;
    logic [31:0] input_tx_am;
    logic        input_tx_am_stb;
    logic        input_tx_am_ack;
    logic [31:0] input_tx_ctl;
    logic        input_tx_ctl_stb;
    logic        input_tx_ctl_ack;

    modport master (
        output input_tx_freq, input_tx_freq_stb,
        output input_tx_am,   input_tx_am_stb,
        output input_tx_ctl,  input_tx_ctl_stb,
        input  input_tx_freq_ack, input_tx_am_ack, input_tx_ctl_ack
    );

    modport slave (
        input  input_tx_freq, input_tx_freq_stb,
        input  input_tx_am,   input_tx_am_stb,
        input  input_tx_ctl,  input_tx_ctl_stb,
        output input_tx_freq_ack, input_tx_am_ack, input_tx_ctl_ack
    );
endinterface

// File: rtl/tx_sample_feeder.sv
// Buffers AM samples and paces them out at a fixed sample period to the modulator.
// Define TX_AM_HOLD_EN to freeze am_out on underrun instead of muting it.
module tx_sample_feeder #(
    parameter int unsigned FIFO_DEPTH_LOG2 = 4,
    parameter int unsigned SAMPLE_DIV      = 1000,
    parameter int unsigned AM_WIDTH        = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    tx_sample_feeder_if.slave        tx,
    output logic [31:0]              freq_out,
    output logic [AM_WIDTH-1:0]      am_out,
    output logic                     tx_enable,
    output logic                     sample_stb,
    output logic                     underrun,
    output logic [FIFO_DEPTH_LOG2:0] fifo_level
);

    localparam logic [FIFO_DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};
    localparam logic [15:0]              TICK_AT    = 16'(SAMPLE_DIV - 1);

    logic [AM_WIDTH-1:0]        mem [(1 << FIFO_DEPTH_LOG2)];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic [15:0]                timer;

    logic                freq_xfer;
    logic                am_xfer;
    logic                ctl_xfer;
    logic                flush;
    logic                tick;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic [AM_WIDTH-1:0] am_next;
    logic                unused_bits;

    always_comb begin
        freq_xfer   = tx.input_tx_freq_stb && tx.input_tx_freq_ack;
        am_xfer     = tx.input_tx_am_stb && tx.input_tx_am_ack;
        ctl_xfer    = tx.input_tx_ctl_stb && tx.input_tx_ctl_ack;
        flush       = ctl_xfer && tx.input_tx_ctl[1];
        tick        = (timer == TICK_AT);
        fifo_empty  = (fifo_level == '0);
        // Flush wins: a same-edge push is dropped and a same-edge tick sees an empty FIFO.
        push        = am_xfer && !flush;
        pop         = tick && tx_enable && !fifo_empty && !flush;
        unused_bits = ^{tx.input_tx_am[31:AM_WIDTH], tx.input_tx_ctl[31:2]};
    end

    always_comb begin
        am_next = am_out;
        if (!tx_enable) begin
            am_next = '0;
        end else if (pop) begin
            am_next = mem[rd_ptr];
        end else begin
`ifdef TX_AM_HOLD_EN
            am_next = am_out;
`else
            am_next = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx.input_tx_am[AM_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx.input_tx_freq_ack <= 1'b0;
            tx.input_tx_am_ack   <= 1'b0;
            tx.input_tx_ctl_ack  <= 1'b0;
            freq_out             <= '0;
            am_out               <= '0;
            tx_enable            <= 1'b0;
            sample_stb           <= 1'b0;
            underrun             <= 1'b0;
            fifo_level           <= '0;
            wr_ptr               <= '0;
            rd_ptr               <= '0;
            timer                <= '0;
        end else begin
            tx.input_tx_freq_ack <= tx.input_tx_freq_stb && !tx.input_tx_freq_ack;
            tx.input_tx_am_ack   <= tx.input_tx_am_stb && !tx.input_tx_am_ack &&
                                    (fifo_level != FULL_LEVEL);
            tx.input_tx_ctl_ack  <= tx.input_tx_ctl_stb && !tx.input_tx_ctl_ack;

            if (freq_xfer) begin
                freq_out <= tx.input_tx_freq;
            end
            if (ctl_xfer) begin
                tx_enable <= tx.input_tx_ctl[0];
            end

            timer      <= tick ? '0 : timer + 16'd1;
            sample_stb <= tick;
            underrun   <= tick && tx_enable && (fifo_empty || flush);
            if (tick) begin
                am_out <= am_next;
            end

            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_level <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + FIFO_DEPTH_LOG2'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + FIFO_DEPTH_LOG2'(1);
                end
                if (push && !pop) begin
                    fifo_level <= fifo_level + (FIFO_DEPTH_LOG2 + 1)'(1);
                end else if (pop && !push) begin
                    fifo_level <= fifo_level - (FIFO_DEPTH_LOG2 + 1)'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_tx_sample_feeder.sv
// Directed and randomized checks of tx_sample_feeder against a queue-based reference model.
// Expected underrun behaviour follows TX_AM_HOLD_EN as compiled.
module tb_tx_sample_feeder;

    localparam int unsigned DIV   = 4;
    localparam int unsigned LOG2  = 4;
    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      freq_out;
    logic [W-1:0]     am_out;
    logic             tx_enable;
    logic             sample_stb;
    logic             underrun;
    logic [LOG2:0]    fifo_level;

    always #5 clk = ~clk;

    tx_sample_feeder_if ifc ();

    tx_sample_feeder #(
        .FIFO_DEPTH_LOG2(LOG2),
        .SAMPLE_DIV     (DIV),
        .AM_WIDTH       (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx        (ifc),
        .freq_out  (freq_out),
        .am_out    (am_out),
        .tx_enable (tx_enable),
        .sample_stb(sample_stb),
        .underrun  (underrun),
        .fifo_level(fifo_level)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: what each output should hold after the latest edge.
    int unsigned  m_cnt;
    logic [31:0]  m_freq;
    logic [W-1:0] m_am;
    logic         m_en, m_stb, m_und;
    logic         m_fack, m_aack, m_cack;
    logic         m_fx, m_ax, m_cx;
    logic [W-1:0] q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("freq_out", freq_out, m_freq);
        chk("am_out", 32'(am_out), 32'(m_am));
        chk("tx_enable", 32'(tx_enable), 32'(m_en));
        chk("sample_stb", 32'(sample_stb), 32'(m_stb));
        chk("underrun", 32'(underrun), 32'(m_und));
        chk("fifo_level", 32'(fifo_level), 32'(q.size()));
        chk("freq_ack", 32'(ifc.input_tx_freq_ack), 32'(m_fack));
        chk("am_ack", 32'(ifc.input_tx_am_ack), 32'(m_aack));
        chk("ctl_ack", 32'(ifc.input_tx_ctl_ack), 32'(m_cack));
    endtask

    task automatic model_reset();
        m_cnt = 0; m_freq = '0; m_am = '0; m_en = 0; m_stb = 0; m_und = 0;
        m_fack = 0; m_aack = 0; m_cack = 0; m_fx = 0; m_ax = 0; m_cx = 0;
        q.delete();
    endtask

    // One clock: capture inputs, advance the model over the edge, compare after the edge.
    task automatic step();
        logic        fs, as, cs, flush, tick;
        logic [31:0] fd, ad, cd;
        int unsigned sz;
        fs = ifc.input_tx_freq_stb; fd = ifc.input_tx_freq;
        as = ifc.input_tx_am_stb;   ad = ifc.input_tx_am;
        cs = ifc.input_tx_ctl_stb;  cd = ifc.input_tx_ctl;
        @(posedge clk);
        m_fx  = fs && m_fack;
        m_ax  = as && m_aack;
        m_cx  = cs && m_cack;
        flush = m_cx && cd[1];
        tick  = (m_cnt == DIV - 1);
        sz    = q.size();
        m_fack = fs && !m_fack;
        m_aack = as && !m_aack && (sz < DEPTH);
        m_cack = cs && !m_cack;
        m_stb = tick;
        m_und = 1'b0;
        if (tick) begin
            if (!m_en) begin
                m_am = '0;
            end else if (flush || sz == 0) begin
                m_und = 1'b1;
`ifndef TX_AM_HOLD_EN
                m_am = '0;
`endif
            end else begin
                m_am = q.pop_front();
            end
        end
        if (m_ax) q.push_back(ad[W-1:0]);
        if (flush) q.delete();
        if (m_fx) m_freq = fd;
        if (m_cx) m_en = cd[0];
        m_cnt = (m_cnt + 1) % DIV;
        #1;
        check_all();
    endtask

    // port: 0 freq, 1 am, 2 ctl. Holds stb until the word transfers or the budget runs out.
    task automatic send(input int port, input logic [31:0] data);
        logic done;
        done = 1'b0;
        case (port)
            0: begin ifc.input_tx_freq = data; ifc.input_tx_freq_stb = 1'b1; end
            1: begin ifc.input_tx_am   = data; ifc.input_tx_am_stb   = 1'b1; end
            default: begin ifc.input_tx_ctl = data; ifc.input_tx_ctl_stb = 1'b1; end
        endcase
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            done = (port == 0) ? m_fx : (port == 1) ? m_ax : m_cx;
        end
        case (port)
            0: ifc.input_tx_freq_stb = 1'b0;
            1: ifc.input_tx_am_stb   = 1'b0;
            default: ifc.input_tx_ctl_stb = 1'b0;
        endcase
        chk("send_done", 32'(done), 32'd1);
    endtask

    task automatic wait_pulse(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (sample_stb !== 1'b1 && n < 20);
        chk("pulse_seen", 32'(sample_stb), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          acks;
        logic        got;
        logic [31:0] r;
        logic [W-1:0] first;

        rst = 1'b1;
        ifc.input_tx_freq = '0; ifc.input_tx_freq_stb = 1'b0;
        ifc.input_tx_am   = '0; ifc.input_tx_am_stb   = 1'b0;
        ifc.input_tx_ctl  = '0; ifc.input_tx_ctl_stb  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // First tick lands DIV edges after reset release.
        repeat (DIV - 1) step();
        chk("pre_first_stb", 32'(sample_stb), 32'd0);
        step();
        chk("first_stb", 32'(sample_stb), 32'd1);

        // Frequency load and alternate-cycle acks under a held stb.
        send(0, 32'h1234_5678);
        chk("freq_load", freq_out, 32'h1234_5678);
        ifc.input_tx_freq = 32'hCAFE_F00D;
        ifc.input_tx_freq_stb = 1'b1;
        acks = 0;
        repeat (8) begin
            step();
            acks += int'(ifc.input_tx_freq_ack);
        end
        ifc.input_tx_freq_stb = 1'b0;
        chk("freq_alt_acks", 32'(acks), 32'd4);

        // Streaming three samples, then an underrun.
        send(2, 32'h2);
        send(1, 32'h11); send(1, 32'h22); send(1, 32'h33);
        send(2, 32'h1);
        wait_pulse(n);
        chk("stream_am0", 32'(am_out), 32'h11);
        chk("stream_und0", 32'(underrun), 32'd0);
        wait_pulse(n);
        chk("stream_gap1", 32'(n), 32'(DIV));
        chk("stream_am1", 32'(am_out), 32'h22);
        wait_pulse(n);
        chk("stream_am2", 32'(am_out), 32'h33);
        wait_pulse(n);
        chk("stream_gap3", 32'(n), 32'(DIV));
        chk("stream_und3", 32'(underrun), 32'd1);
`ifdef TX_AM_HOLD_EN
        chk("stream_am3", 32'(am_out), 32'h33);
`else
        chk("stream_am3", 32'(am_out), 32'h00);
`endif

        // Full FIFO: 17th word waits until an enabled tick frees a slot.
        send(2, 32'h2);
        for (int i = 0; i < 16; i++) send(1, $urandom);
        chk("full_level", 32'(fifo_level), 32'd16);
        ifc.input_tx_am = 32'h0000_00A5;
        ifc.input_tx_am_stb = 1'b1;
        acks = 0;
        repeat (6) begin
            step();
            acks += int'(ifc.input_tx_am_ack);
        end
        chk("full_no_ack", 32'(acks), 32'd0);
        send(2, 32'h1);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            got = m_ax;
        end
        ifc.input_tx_am_stb = 1'b0;
        chk("full_accept", 32'(got), 32'd1);
        chk("full_level_after", 32'(fifo_level), 32'd16);

        // Flush collision: control 0x3, AM transfer and tick on one edge.
        repeat (6) step();
        for (int i = 0; i < 8 && m_cnt != DIV - 2; i++) step();
        ifc.input_tx_am  = 32'h0000_005A; ifc.input_tx_am_stb  = 1'b1;
        ifc.input_tx_ctl = 32'h3;         ifc.input_tx_ctl_stb = 1'b1;
        step();
        step();
        ifc.input_tx_am_stb = 1'b0; ifc.input_tx_ctl_stb = 1'b0;
        chk("collide_level", 32'(fifo_level), 32'd0);
        chk("collide_stb", 32'(sample_stb), 32'd1);
        chk("collide_underrun", 32'(underrun), 32'd1);
        step();

        // Disable with samples queued: output mutes, queue is kept.
        send(2, 32'h2);
        for (int i = 0; i < 6; i++) send(1, 32'h40 + 32'(i));
        send(2, 32'h1);
        wait_pulse(n);
        first = am_out;
        chk("dis_first", 32'(first), 32'h40);
        chk("dis_level5", 32'(fifo_level), 32'd5);
        send(2, 32'h0);
        wait_pulse(n);
        chk("dis_am", 32'(am_out), 32'd0);
        chk("dis_level", 32'(fifo_level), 32'd5);
        chk("dis_underrun", 32'(underrun), 32'd0);

        // Randomized traffic; producers hold data until their word transfers.
        for (int c = 0; c < 400; c++) begin
            if (!ifc.input_tx_freq_stb || m_fx) begin
                ifc.input_tx_freq_stb = 1'($urandom_range(0, 1));
                ifc.input_tx_freq = $urandom;
            end
            if (!ifc.input_tx_am_stb || m_ax) begin
                ifc.input_tx_am_stb = ($urandom_range(0, 3) != 0);
                ifc.input_tx_am = $urandom;
            end
            if (!ifc.input_tx_ctl_stb || m_cx) begin
                r = $urandom;
                r[0] = ($urandom_range(0, 3) != 0);
                r[1] = ($urandom_range(0, 7) == 0);
                ifc.input_tx_ctl_stb = ($urandom_range(0, 5) == 0);
                ifc.input_tx_ctl = r;
            end
            step();
        end
        ifc.input_tx_freq_stb = 1'b0; ifc.input_tx_am_stb = 1'b0; ifc.input_tx_ctl_stb = 1'b0;
        step();

        // Reset in the middle of an AM handshake.
        send(2, 32'h2);
        send(1, 32'h44);
        ifc.input_tx_am = 32'h77;
        ifc.input_tx_am_stb = 1'b1;
        for (int i = 0; i < 10 && !m_aack; i++) step();
        chk("pre_rst_ack", 32'(ifc.input_tx_am_ack), 32'd1);
        rst = 1'b1;
        ifc.input_tx_am_stb = 1'b0;
        #1;
        chk("rst_am_ack", 32'(ifc.input_tx_am_ack), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_freq", freq_out, 32'd0);
        chk("rst_am", 32'(am_out), 32'd0);
        chk("rst_en", 32'(tx_enable), 32'd0);
        chk("rst_stb", 32'(sample_stb), 32'd0);
        chk("rst_und", 32'(underrun), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(2, 32'h1);
        wait_pulse(n);
        chk("post_rst_underrun", 32'(underrun), 32'd1);
        chk("post_rst_level", 32'(fifo_level), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
